// File: rtl/t06_lcd_cmd_sequencer_if.sv
// Handshake between the update controller and the LCD command sequencer,
// plus the 8080-style pins the sequencer drives.
interface t06_lcd_cmd_sequencer_if;
  logic        wr;
  logic [2:0]  mode;
  logic [8:0]  x0;
  logic [8:0]  x1;
  logic [8:0]  y0;
  logic [8:0]  y1;
  logic [16:0] win_pixels;
  logic [15:0] color;
  logic        pause;
  logic        cmd_finished;
  logic        lcd_csx;
  logic        lcd_dcx;
  logic        lcd_wrx;
  logic [7:0]  lcd_data;

  modport master (
    output wr, mode, x0, x1, y0, y1, win_pixels, color,
    input  pause, cmd_finished, lcd_csx, lcd_dcx, lcd_wrx, lcd_data
  );

  modport slave (
    input  wr, mode, x0, x1, y0, y1, win_pixels, color,
    output pause, cmd_finished, lcd_csx, lcd_dcx, lcd_wrx, lcd_data
  );
endinterface

// File: rtl/t06_lcd_cmd_sequencer.sv
// Emits one LCD command/data byte per controller wr strobe (INIT or UPDATE
// sequence selected by mode), paces the controller through pause.
module t06_lcd_cmd_sequencer #(
  parameter int unsigned WR_LOW    = 2,
  parameter int unsigned WR_HIGH   = 2,
  parameter int unsigned CMD_DELAY = 16
) (
  input logic                      clk,
  input logic                      nrst,
  t06_lcd_cmd_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, STROBE_LO, STROBE_HI, DELAY} state_e;

  localparam logic [15:0] LO_LAST   = 16'(WR_LOW - 1);
  localparam logic [15:0] HI_LAST   = 16'(WR_HIGH - 1);
  localparam logic [15:0] DLY_LAST  = 16'(CMD_DELAY - 1);
  localparam bit          HAS_DELAY = (CMD_DELAY != 0);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [17:0] idx_q, idx_d;
  logic [17:0] last_q, last_d;
  logic [8:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [7:0]  color_lo_q, color_lo_d;
  logic        fin_q, fin_d;
  logic        dly_q, dly_d;
  logic        pause_q, pause_d;
  logic        csx_q, csx_d;
  logic        dcx_q, dcx_d;
  logic        wrx_q, wrx_d;
  logic [7:0]  data_q, data_d;

  logic        is_init;
  logic        is_upd;
  logic        accept;
  logic        finished;
  logic [7:0]  byte_val;
  logic        byte_dc;

  assign is_init  = (bus.mode == 3'd1) || (bus.mode == 3'd3);
  assign is_upd   = (bus.mode == 3'd2) || (bus.mode == 3'd4);
  assign accept   = (state_q == IDLE) && bus.wr && (is_init || is_upd);
  // idx 0 can never be last, which also masks last_q before it is loaded
  assign finished = accept && (idx_q != '0) && (idx_q == last_q);

  assign bus.cmd_finished = finished;
  assign bus.pause        = pause_q;
  assign bus.lcd_csx      = csx_q;
  assign bus.lcd_dcx      = dcx_q;
  assign bus.lcd_wrx      = wrx_q;
  assign bus.lcd_data     = data_q;

  always_comb begin
    byte_val = 8'h00;
    byte_dc  = 1'b0;
    if (is_init) begin
      case (idx_q)
        18'd0:   byte_val = 8'h01;
        18'd1:   byte_val = 8'h11;
        18'd2:   byte_val = 8'h3A;
        18'd3:   begin byte_val = 8'h55; byte_dc = 1'b1; end
        18'd4:   byte_val = 8'h36;
        18'd5:   begin byte_val = 8'h00; byte_dc = 1'b1; end
        18'd6:   byte_val = 8'h29;
        default: ;
      endcase
    end else begin
      case (idx_q)
        18'd0:   byte_val = 8'h2A;
        18'd1:   begin byte_val = {7'b0, x0_q[8]}; byte_dc = 1'b1; end
        18'd2:   begin byte_val = x0_q[7:0];       byte_dc = 1'b1; end
        18'd3:   begin byte_val = {7'b0, x1_q[8]}; byte_dc = 1'b1; end
        18'd4:   begin byte_val = x1_q[7:0];       byte_dc = 1'b1; end
        18'd5:   byte_val = 8'h2B;
        18'd6:   begin byte_val = {7'b0, y0_q[8]}; byte_dc = 1'b1; end
        18'd7:   begin byte_val = y0_q[7:0];       byte_dc = 1'b1; end
        18'd8:   begin byte_val = {7'b0, y1_q[8]}; byte_dc = 1'b1; end
        18'd9:   begin byte_val = y1_q[7:0];       byte_dc = 1'b1; end
        18'd10:  byte_val = 8'h2C;
        // pixel bytes start at odd idx 11: odd = high byte, even = held low byte
        default: begin
          byte_dc  = 1'b1;
          byte_val = idx_q[0] ? bus.color[15:8] : color_lo_q;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    color_lo_d = color_lo_q;
    fin_d      = fin_q;
    dly_d      = dly_q;
    pause_d    = pause_q;
    csx_d      = csx_q;
    dcx_d      = dcx_q;
    wrx_d      = wrx_q;
    data_d     = data_q;

    if (bus.mode == 3'd0) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      last_d  = '0;
      x0_d    = '0;
      x1_d    = '0;
      y0_d    = '0;
      y1_d    = '0;
      fin_d   = 1'b0;
      dly_d   = 1'b0;
      pause_d = 1'b0;
      csx_d   = 1'b1;
      wrx_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = STROBE_LO;
            cnt_d   = '0;
            data_d  = byte_val;
            dcx_d   = byte_dc;
            csx_d   = 1'b0;
            wrx_d   = 1'b0;
            pause_d = 1'b1;
            fin_d   = finished;
            dly_d   = is_init && (idx_q[17:1] == '0);
            idx_d   = finished ? '0 : idx_q + 18'd1;
            if (idx_q == '0) begin
              x0_d   = bus.x0;
              x1_d   = bus.x1;
              y0_d   = bus.y0;
              y1_d   = bus.y1;
              last_d = is_init ? 18'd6 : 18'd10 + {bus.win_pixels, 1'b0};
            end
            if (is_upd && (idx_q >= 18'd11) && idx_q[0]) begin
              color_lo_d = bus.color[7:0];
            end
          end
        end
        STROBE_LO: begin
          if (cnt_q == LO_LAST) begin
            state_d = STROBE_HI;
            cnt_d   = '0;
            wrx_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        STROBE_HI: begin
          if (cnt_q == HI_LAST) begin
            cnt_d = '0;
            if (dly_q && HAS_DELAY) begin
              state_d = DELAY;
            end else begin
              state_d = IDLE;
              pause_d = 1'b0;
              if (fin_q) csx_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        DELAY: begin
          if (cnt_q == DLY_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            pause_d = 1'b0;
            if (fin_q) csx_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_lo_q <= '0;
      fin_q      <= 1'b0;
      dly_q      <= 1'b0;
      pause_q    <= 1'b0;
      csx_q      <= 1'b1;
      dcx_q      <= 1'b1;
      wrx_q      <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      color_lo_q <= color_lo_d;
      fin_q      <= fin_d;
      dly_q      <= dly_d;
      pause_q    <= pause_d;
      csx_q      <= csx_d;
      dcx_q      <= dcx_d;
      wrx_q      <= wrx_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_t06_lcd_cmd_sequencer.sv
// Directed + randomized bench for t06_lcd_cmd_sequencer; expected bus bytes
// come from a queue-based model of the INIT/UPDATE byte lists.
module tb_t06_lcd_cmd_sequencer;
  localparam int unsigned WL = 2;
  localparam int unsigned WH = 2;
  localparam int unsigned CD = 16;

  typedef logic [8:0] bus_byte_t;   // {dcx, data}

  logic clk = 1'b0;
  logic nrst;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bus_byte_t   exp_q[$];
  int unsigned cols[$];
  int unsigned spoil[$];
  int unsigned wx0, wx1, wy0, wy1, wnp;

  t06_lcd_cmd_sequencer_if bif();

  t06_lcd_cmd_sequencer #(
    .WR_LOW(WL),
    .WR_HIGH(WH),
    .CMD_DELAY(CD)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_init();
    exp_q.delete();
    exp_q = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h029};
  endfunction

  function automatic void push_word(input int unsigned v);
    exp_q.push_back({1'b1, 8'(v / 256)});
    exp_q.push_back({1'b1, 8'(v % 256)});
  endfunction

  function automatic void model_update();
    exp_q.delete();
    exp_q.push_back(9'h02A);
    push_word(wx0);
    push_word(wx1);
    exp_q.push_back(9'h02B);
    push_word(wy0);
    push_word(wy1);
    exp_q.push_back(9'h02C);
    for (int p = 0; p < int'(wnp); p++) push_word(cols[p]);
  endfunction

  task automatic send_byte(input bus_byte_t exp, input bit exp_last, input bit exp_dly,
                           input bit inject);
    int n = 0;
    while (bif.pause !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_pause", bif.pause, 0);
    bif.wr = 1'b1;
    #1;
    chk("cmd_finished", bif.cmd_finished, exp_last);
    @(negedge clk);
    bif.wr = 1'b0;
    chk("t1_pause", bif.pause, 1);
    chk("t1_wrx", bif.lcd_wrx, 0);
    chk("t1_csx", bif.lcd_csx, 0);
    chk("t1_data", bif.lcd_data, exp[7:0]);
    chk("t1_dcx", bif.lcd_dcx, exp[8]);
    if (inject) begin
      bif.wr = 1'b1;
      #1;
      chk("stray_cmd_finished", bif.cmd_finished, 0);
      @(posedge clk);
      #1 bif.wr = 1'b0;
    end
    for (int i = 1; i < int'(WL); i++) begin
      @(negedge clk);
      chk("lo_wrx", bif.lcd_wrx, 0);
      chk("lo_data", bif.lcd_data, exp[7:0]);
    end
    for (int i = 0; i < int'(WH); i++) begin
      @(negedge clk);
      chk("hi_wrx", bif.lcd_wrx, 1);
      chk("hi_pause", bif.pause, 1);
      chk("hi_bus", {bif.lcd_dcx, bif.lcd_data}, exp);
    end
    if (exp_dly) begin
      for (int i = 0; i < int'(CD); i++) begin
        @(negedge clk);
        chk("dly_pause", bif.pause, 1);
      end
    end
    @(negedge clk);
    chk("end_pause", bif.pause, 0);
    chk("end_csx", bif.lcd_csx, exp_last);
    chk("end_wrx", bif.lcd_wrx, 1);
  endtask

  task automatic run_seq(input bit init, input int inject_at);
    int unsigned p;
    if (!init) begin
      bif.x0 = 9'(wx0);
      bif.x1 = 9'(wx1);
      bif.y0 = 9'(wy0);
      bif.y1 = 9'(wy1);
      bif.win_pixels = 17'(wnp);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (!init && i == 1) begin
        // window must already be latched; scramble the live inputs
        bif.x0 = 9'($urandom_range(0, 511));
        bif.x1 = 9'($urandom_range(0, 511));
        bif.y0 = 9'($urandom_range(0, 511));
        bif.y1 = 9'($urandom_range(0, 511));
        bif.win_pixels = 17'($urandom_range(1, 60000));
      end
      if (!init && i >= 11) begin
        p = (i - 11) / 2;
        bif.color = 16'(((i - 11) % 2 == 0) ? cols[p] : spoil[p]);
      end
      send_byte(exp_q[i], i == exp_q.size() - 1,
                init && (i < 2), i == inject_at);
    end
  endtask

  initial begin
    nrst = 1'b1;
    bif.wr = 1'b0;
    bif.mode = 3'd0;
    bif.x0 = '0;
    bif.x1 = '0;
    bif.y0 = '0;
    bif.y1 = '0;
    bif.win_pixels = 17'd1;
    bif.color = '0;
    #1 nrst = 1'b0;
    #12;
    chk("rst_pause", bif.pause, 0);
    chk("rst_csx", bif.lcd_csx, 1);
    chk("rst_dcx", bif.lcd_dcx, 1);
    chk("rst_wrx", bif.lcd_wrx, 1);
    chk("rst_data", bif.lcd_data, 0);
    chk("rst_cmd_finished", bif.cmd_finished, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // INIT with defaults
    bif.mode = 3'd3;
    model_init();
    run_seq(1'b1, -1);

    // UPDATE directed window
    bif.mode = 3'd4;
    wx0 = 0; wx1 = 1; wy0 = 0; wy1 = 0; wnp = 2;
    cols = '{32'hF800, 32'hF800};
    spoil = '{32'hF800, 32'hF800};
    model_update();
    run_seq(1'b0, -1);

    // color changed between high and low byte
    cols = '{32'hF800, 32'h07E0};
    spoil = '{32'h07E0, 32'h07E0};
    model_update();
    run_seq(1'b0, -1);

    // stray wr while busy, right before the last INIT byte
    bif.mode = 3'd1;
    model_init();
    run_seq(1'b1, 5);

    // mode 5 ignores wr
    bif.mode = 3'd5;
    bif.wr = 1'b1;
    #1;
    chk("m5_cmd_finished", bif.cmd_finished, 0);
    @(negedge clk);
    bif.wr = 1'b0;
    chk("m5_pause", bif.pause, 0);
    chk("m5_wrx", bif.lcd_wrx, 1);
    chk("m5_csx", bif.lcd_csx, 1);

    // abort with mode 0 during STROBE_LO of byte 3
    bif.mode = 3'd3;
    model_init();
    for (int i = 0; i < 3; i++) send_byte(exp_q[i], 1'b0, i < 2, 1'b0);
    bif.wr = 1'b1;
    #1;
    chk("abort_cmd_finished", bif.cmd_finished, 0);
    @(negedge clk);
    bif.wr = 1'b0;
    chk("abort_wrx_lo", bif.lcd_wrx, 0);
    bif.mode = 3'd0;
    @(negedge clk);
    chk("abort_wrx", bif.lcd_wrx, 1);
    chk("abort_csx", bif.lcd_csx, 1);
    chk("abort_pause", bif.pause, 0);
    bif.mode = 3'd3;
    @(negedge clk);
    run_seq(1'b1, -1);

    // async reset during the delay after SLPOUT
    send_byte(exp_q[0], 1'b0, 1'b1, 1'b0);
    bif.wr = 1'b1;
    @(negedge clk);
    bif.wr = 1'b0;
    repeat (WL + WH + 3) @(negedge clk);
    chk("pre_rst_pause", bif.pause, 1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_pause", bif.pause, 0);
    chk("arst_csx", bif.lcd_csx, 1);
    chk("arst_dcx", bif.lcd_dcx, 1);
    chk("arst_wrx", bif.lcd_wrx, 1);
    chk("arst_data", bif.lcd_data, 0);
    chk("arst_cmd_finished", bif.cmd_finished, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_seq(1'b1, -1);

    // randomized UPDATE windows
    for (int r = 0; r < 6; r++) begin
      bif.mode = (r % 2 == 1) ? 3'd2 : 3'd4;
      wx0 = $urandom_range(0, 511);
      wx1 = $urandom_range(0, 511);
      wy0 = $urandom_range(0, 511);
      wy1 = $urandom_range(0, 511);
      wnp = $urandom_range(1, 4);
      cols.delete();
      spoil.delete();
      for (int p = 0; p < int'(wnp); p++) begin
        cols.push_back($urandom_range(0, 65535));
        spoil.push_back($urandom_range(0, 65535));
      end
      model_update();
      run_seq(1'b0, int'($urandom_range(0, exp_q.size() - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
